// File: rtl/signed_fxp_div_if.sv
// Request/result bundle for the signed_fxp_div fixed-point divider.
// The master drives operands and the request strobe; the slave returns results.
interface signed_fxp_div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic             signed_in;
  logic             data_valid_in;
  logic [WIDTH-1:0] quotient_out;
  logic [WIDTH-1:0] remainder_out;
  logic             data_valid_out;
  logic             error_out;
  logic             overflow_out;
  logic             busy_out;

  modport master (
    output dividend_in, divisor_in, signed_in, data_valid_in,
    input  quotient_out, remainder_out, data_valid_out, error_out, overflow_out, busy_out
  );

  modport slave (
    input  dividend_in, divisor_in, signed_in, data_valid_in,
    output quotient_out, remainder_out, data_valid_out, error_out, overflow_out, busy_out
  );
endinterface

// File: rtl/signed_fxp_div.sv
// Fixed-latency radix-2 restoring divider for signed/unsigned fixed-point operands.
// Quotient = (dividend * 2^FRAC) / divisor, truncated toward zero, saturating on overflow.
module signed_fxp_div #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 0
) (
  input logic            clk_in,
  input logic            rst_in,
  signed_fxp_div_if.slave bus
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
  localparam logic [N:0] SMIN_MAG = (N+1)'(1) << (WIDTH - 1);
  localparam logic [N:0] SMAX     = SMIN_MAG - (N+1)'(1);
  localparam logic [N:0] UMAX     = ((N+1)'(1) << WIDTH) - (N+1)'(1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIX} state_t;

  state_t           state_q;
  logic [CW-1:0]    iter_q;
  logic             isSigned_q;
  logic             dvdNeg_q;
  logic             dvsNeg_q;
  logic [WIDTH-1:0] dvsMag_q;
  logic [WIDTH-1:0] dvdRaw_q;
  logic [WIDTH-1:0] rem_q;
  logic [N-1:0]     dvdShift_q;
  logic [N-1:0]     quo_q;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             valid_q;
  logic             error_q;
  logic             overflow_q;
  logic             busy_q;

  logic             accept_d;
  logic [WIDTH-1:0] dvdMag_d;
  logic [WIDTH-1:0] dvsMag_d;
  logic [WIDTH:0]   remShift_d;
  logic [WIDTH:0]   trial_d;
  logic             quoNeg_d;
  logic             remNeg_d;
  logic [N:0]       quoExt_d;
  logic [WIDTH-1:0] quoLow_d;
  logic             divZero_d;
  logic             ovf_d;
  logic [WIDTH-1:0] quoFinal_d;
  logic [WIDTH-1:0] remFinal_d;

  // FIX doubles as an accept slot so back-to-back requests see one result per N+1 cycles.
  always_comb begin
    accept_d = bus.data_valid_in && ((state_q == IDLE) || (state_q == FIX));
    dvdMag_d = (bus.signed_in && bus.dividend_in[WIDTH-1]) ? -bus.dividend_in : bus.dividend_in;
    dvsMag_d = (bus.signed_in && bus.divisor_in[WIDTH-1])  ? -bus.divisor_in  : bus.divisor_in;
    remShift_d = {rem_q, dvdShift_q[N-1]};
    trial_d    = remShift_d - {1'b0, dvsMag_q};
  end

  always_comb begin
    quoNeg_d  = (dvdNeg_q ^ dvsNeg_q) && (quo_q != '0);
    remNeg_d  = dvdNeg_q && (rem_q != '0);
    quoExt_d  = {1'b0, quo_q};
    quoLow_d  = quo_q[WIDTH-1:0];
    divZero_d = (dvsMag_q == '0);
    if (isSigned_q) begin
      ovf_d = quoNeg_d ? (quoExt_d > SMIN_MAG) : (quoExt_d > SMAX);
    end else begin
      ovf_d = (quoExt_d > UMAX);
    end
    remFinal_d = remNeg_d ? -rem_q : rem_q;
    if (divZero_d) begin
      quoFinal_d = '0;
      remFinal_d = dvdRaw_q;
    end else if (ovf_d) begin
      if (isSigned_q) begin
        quoFinal_d = quoNeg_d ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        quoFinal_d = '1;
      end
    end else begin
      quoFinal_d = quoNeg_d ? -quoLow_d : quoLow_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      isSigned_q  <= 1'b0;
      dvdNeg_q    <= 1'b0;
      dvsNeg_q    <= 1'b0;
      dvsMag_q    <= '0;
      dvdRaw_q    <= '0;
      rem_q       <= '0;
      dvdShift_q  <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: ;
        DIVIDE: begin
          dvdShift_q <= dvdShift_q << 1;
          iter_q     <= iter_q + CW'(1);
          if (!trial_d[WIDTH]) begin
            rem_q <= trial_d[WIDTH-1:0];
            quo_q <= {quo_q[N-2:0], 1'b1};
          end else begin
            rem_q <= remShift_d[WIDTH-1:0];
            quo_q <= {quo_q[N-2:0], 1'b0};
          end
          if (iter_q == LAST_ITER) state_q <= FIX;
        end
        FIX: begin
          quotient_q  <= quoFinal_d;
          remainder_q <= remFinal_d;
          error_q     <= divZero_d;
          overflow_q  <= !divZero_d && ovf_d;
          valid_q     <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A new request overrides the FIX->IDLE return and reloads the datapath.
      if (accept_d) begin
        state_q    <= DIVIDE;
        busy_q     <= 1'b1;
        iter_q     <= '0;
        isSigned_q <= bus.signed_in;
        dvdNeg_q   <= bus.signed_in && bus.dividend_in[WIDTH-1];
        dvsNeg_q   <= bus.signed_in && bus.divisor_in[WIDTH-1];
        dvsMag_q   <= dvsMag_d;
        dvdRaw_q   <= bus.dividend_in;
        rem_q      <= '0;
        quo_q      <= '0;
        dvdShift_q <= N'(dvdMag_d) << FRAC;
      end
    end
  end

  assign bus.quotient_out   = quotient_q;
  assign bus.remainder_out  = remainder_q;
  assign bus.data_valid_out = valid_q;
  assign bus.error_out      = error_q;
  assign bus.overflow_out   = overflow_q;
  assign bus.busy_out       = busy_q;
endmodule

// File: tb/tb_signed_fxp_div.sv
// Directed self-checking bench for signed_fxp_div: WIDTH=8 with FRAC=0 and FRAC=4 instances.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_signed_fxp_div;
  logic clk;
  logic rst;
  logic [7:0] tbDividend;
  logic [7:0] tbDivisor;
  logic tbSigned;
  logic dv0;
  logic dv1;
  logic sel;
  int total;
  int bad;

  signed_fxp_div_if #(.WIDTH(8)) bus0 ();
  signed_fxp_div_if #(.WIDTH(8)) bus1 ();

  assign bus0.dividend_in   = tbDividend;
  assign bus0.divisor_in    = tbDivisor;
  assign bus0.signed_in     = tbSigned;
  assign bus0.data_valid_in = dv0;
  assign bus1.dividend_in   = tbDividend;
  assign bus1.divisor_in    = tbDivisor;
  assign bus1.signed_in     = tbSigned;
  assign bus1.data_valid_in = dv1;

  signed_fxp_div #(.WIDTH(8), .FRAC(0)) dut0 (.clk_in(clk), .rst_in(rst), .bus(bus0.slave));
  signed_fxp_div #(.WIDTH(8), .FRAC(4)) dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1.slave));

  logic [7:0] obsQ;
  logic [7:0] obsR;
  logic obsValid;
  logic obsErr;
  logic obsOvf;
  logic obsBusy;
  assign obsQ     = sel ? bus1.quotient_out   : bus0.quotient_out;
  assign obsR     = sel ? bus1.remainder_out  : bus0.remainder_out;
  assign obsValid = sel ? bus1.data_valid_out : bus0.data_valid_out;
  assign obsErr   = sel ? bus1.error_out      : bus0.error_out;
  assign obsOvf   = sel ? bus1.overflow_out   : bus0.overflow_out;
  assign obsBusy  = sel ? bus1.busy_out       : bus0.busy_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One request on the selected instance; waits a bounded time for the result.
  task automatic applyStimulus(input string name, input logic s, input logic [7:0] a,
                               input logic [7:0] b, input logic sg, input logic [7:0] expQ,
                               input logic [7:0] expR, input logic expErr, input logic expOvf,
                               input int expLat);
    int lat;
    int lowCnt;
    sel = s;
    tbDividend = a;
    tbDivisor = b;
    tbSigned = sg;
    if (s) dv1 = 1'b1; else dv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dv0 = 1'b0;
    dv1 = 1'b0;
    lat = 0;
    lowCnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (obsValid) begin
        lat = c;
        break;
      end
      if (!obsBusy) lowCnt++;
    end
    checkOutput({name, "_latency"}, 16'(lat), 16'(expLat));
    checkOutput({name, "_busy_low"}, 16'(lowCnt), 16'd0);
    checkOutput({name, "_q"}, 16'(obsQ), 16'(expQ));
    checkOutput({name, "_r"}, 16'(obsR), 16'(expR));
    checkOutput({name, "_err"}, 16'(obsErr), 16'(expErr));
    checkOutput({name, "_ovf"}, 16'(obsOvf), 16'(expOvf));
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_pulse"}, 16'(obsValid), 16'd0);
    checkOutput({name, "_hold_q"}, 16'(obsQ), 16'(expQ));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    dv0 = 1'b0;
    dv1 = 1'b0;
    sel = 1'b0;
    tbDividend = '0;
    tbDivisor = '0;
    tbSigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checkOutput($sformatf("reset_q_%0d", s), 16'(obsQ), 16'd0);
      checkOutput($sformatf("reset_r_%0d", s), 16'(obsR), 16'd0);
      checkOutput($sformatf("reset_flags_%0d", s), 16'({obsValid, obsErr, obsOvf, obsBusy}), 16'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("sn7_d2",    1'b0, 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, 9);
    applyStimulus("s7_dn2",    1'b0, 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1'b0, 9);
    applyStimulus("sn7_dn2",   1'b0, 8'hF9, 8'hFE, 1'b1, 8'h03, 8'hFF, 1'b0, 1'b0, 9);
    applyStimulus("smin_dn1",  1'b0, 8'h80, 8'hFF, 1'b1, 8'h7F, 8'h00, 1'b0, 1'b1, 9);
    applyStimulus("smin_d1",   1'b0, 8'h80, 8'h01, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 9);
    applyStimulus("s5_d0",     1'b0, 8'h05, 8'h00, 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 9);
    applyStimulus("sn3_d0",    1'b0, 8'hFD, 8'h00, 1'b1, 8'h00, 8'hFD, 1'b1, 1'b0, 9);
    applyStimulus("u200_d7",   1'b0, 8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 9);
    applyStimulus("uff_d1",    1'b0, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 9);

    // Requests sampled at edges 0, 3 and 9; the one at 3 lands mid-operation.
    sel = 1'b0;
    tbSigned = 1'b1;
    for (int k = 0; k < 20; k++) begin
      dv0 = (k == 0) || (k == 3) || (k == 9);
      if (k == 0) begin
        tbDividend = 8'd20;
        tbDivisor = 8'd3;
      end else if (k == 3) begin
        tbDividend = 8'd50;
        tbDivisor = 8'd5;
      end else if (k == 9) begin
        tbDividend = 8'hF7;
        tbDivisor = 8'h04;
      end
      @(posedge clk);
      @(negedge clk);
      dv0 = 1'b0;
      checkOutput($sformatf("hs_valid_%0d", k), 16'(obsValid), 16'((k == 9) || (k == 18)));
      checkOutput($sformatf("hs_busy_%0d", k), 16'(obsBusy), 16'(k <= 17));
      if (k == 9) begin
        checkOutput("hs_q_first", 16'(obsQ), 16'h06);
        checkOutput("hs_r_first", 16'(obsR), 16'h02);
      end
      if (k == 18) begin
        checkOutput("hs_q_second", 16'(obsQ), 16'hFE);
        checkOutput("hs_r_second", 16'(obsR), 16'hFF);
      end
    end

    applyStimulus("f4_3_d2",   1'b1, 8'h03, 8'h02, 1'b1, 8'h18, 8'h00, 1'b0, 1'b0, 13);
    applyStimulus("f4_n1_d3",  1'b1, 8'hFF, 8'h03, 1'b1, 8'hFB, 8'hFF, 1'b0, 1'b0, 13);
    applyStimulus("f4_100_d1", 1'b1, 8'h64, 8'h01, 1'b1, 8'h7F, 8'h00, 1'b0, 1'b1, 13);

    // Leave a nonzero result on dut0 so the reset clear is visible.
    applyStimulus("pre_rst",   1'b0, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 9);
    sel = 1'b0;
    tbSigned = 1'b1;
    for (int k = 0; k < 17; k++) begin
      rst = (k == 4);
      dv0 = (k == 0) || (k == 6);
      if (k == 0) begin
        tbDividend = 8'd50;
        tbDivisor = 8'd5;
      end else if (k == 6) begin
        tbDividend = 8'd100;
        tbDivisor = 8'd9;
      end
      @(posedge clk);
      @(negedge clk);
      dv0 = 1'b0;
      rst = 1'b0;
      checkOutput($sformatf("rst_valid_%0d", k), 16'(obsValid), 16'(k == 15));
      if (k == 4) begin
        checkOutput("rst_q", 16'(obsQ), 16'd0);
        checkOutput("rst_r", 16'(obsR), 16'd0);
        checkOutput("rst_busy", 16'(obsBusy), 16'd0);
        checkOutput("rst_flags", 16'({obsErr, obsOvf}), 16'd0);
      end
      if (k == 15) begin
        checkOutput("rst_after_q", 16'(obsQ), 16'h0B);
        checkOutput("rst_after_r", 16'(obsR), 16'h01);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
